// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32 core: sequences the shared ALU, the
// unified memory port and the register-file write port, with a sticky trap and a retire counter.

module instruction_decoder (
  input  logic [31:0] instr,
  output logic        is_r,
  output logic        is_i,
  output logic        is_s,
  output logic        is_b,
  output logic        is_j,
  output logic        is_u
);
  logic [6:0] opcode;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign unused_fields = ^instr[31:7];

  // Loads (0000011) and ALU-immediate (0010011) both count as I-type.
  assign is_r = (opcode == 7'b0110011);
  assign is_i = (opcode == 7'b0000011) || (opcode == 7'b0010011);
  assign is_s = (opcode == 7'b0100011);
  assign is_b = (opcode == 7'b1100011);
  assign is_j = (opcode == 7'b1101111);
  assign is_u = (opcode == 7'b0110111);
endmodule

module multicycle_controller (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [3:0]  state_dbg
);
  typedef enum logic [3:0] {
    RESET = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMREAD = 4'd4,
    MEMWB = 4'd5, MEMWRITE = 4'd6, EXECUTER = 4'd7, EXECUTEI = 4'd8, ALUWB = 4'd9,
    BEQ = 4'd10, JAL = 4'd11, LUI = 4'd12, TRAP = 4'd13
  } state_t;

  state_t state, next;
  logic   is_r, is_i, is_s, is_b, is_j, is_u;
  logic   retire;

  instruction_decoder u_dec (
    .instr(Instr), .is_r(is_r), .is_i(is_i), .is_s(is_s),
    .is_b(is_b), .is_j(is_j), .is_u(is_u)
  );

  assign state_dbg = state;
  assign retire    = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                     ((state == MEMWRITE) && mem_ready);

  always_comb begin
    next = TRAP;
    case (state)
      RESET:    next = FETCH;
      FETCH:    next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if      (is_r)            next = EXECUTER;
        else if (is_i && Instr[4]) next = EXECUTEI;
        else if (is_i || is_s)    next = MEMADR;
        else if (is_b)            next = BEQ;
        else if (is_j)            next = JAL;
        else if (is_u)            next = LUI;
        else                      next = TRAP;
      end
      MEMADR:   next = Instr[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    next = FETCH;
      MEMWRITE: next = mem_ready ? FETCH : MEMWRITE;
      EXECUTER: next = ALUWB;
      EXECUTEI: next = ALUWB;
      ALUWB:    next = FETCH;
      BEQ:      next = FETCH;
      JAL:      next = ALUWB;
      LUI:      next = ALUWB;
      default:  next = TRAP;
    endcase
  end

  // Moore decode; only the FETCH load strobes and the BEQ PC strobe see inputs.
  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:  begin mem_req = 1'b1; AdrSrc = 1'b1; end
      MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      MEMWRITE: begin mem_req = 1'b1; AdrSrc = 1'b1; MemWrite = 1'b1; end
      EXECUTER: begin ALUSrcA = 2'b10; ALUOp = 2'b10; end
      EXECUTEI: begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
      ALUWB:    RegWrite = 1'b1;
      BEQ:      begin ALUSrcA = 2'b10; ALUOp = 2'b01; PCWrite = Zero; end
      JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
      LUI:      begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET;
      illegal <= 1'b0;
      instret <= 32'd0;
    end else begin
      state <= next;
      if (next == TRAP) illegal <= 1'b1;
      if (retire)       instret <= instret + 32'd1;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: each instruction is expanded into its
// expected state path from its opcode class, and every cycle is checked against that path.
module tb_multicycle_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Instr;
  logic        Zero, mem_ready;
  logic        mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic        illegal;
  logic [31:0] instret;
  logic [3:0]  state_dbg;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = 32'd0;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal(illegal), .instret(instret),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
  function automatic logic [13:0] ctl(input int s, input logic r, input logic z);
    case (s)
      1:  return {1'b1, 1'b0, 1'b0, r, r, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
      2:  return {6'b0, 2'b00, 2'b01, 2'b01, 2'b00};
      3:  return {6'b0, 2'b00, 2'b10, 2'b01, 2'b00};
      4:  return {6'b110000, 2'b00, 2'b00, 2'b00, 2'b00};
      5:  return {6'b000001, 2'b01, 2'b00, 2'b00, 2'b00};
      6:  return {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00};
      7:  return {6'b0, 2'b00, 2'b10, 2'b00, 2'b10};
      8:  return {6'b0, 2'b00, 2'b10, 2'b01, 2'b10};
      9:  return {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00};
      10: return {4'b0000, z, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01};
      11: return {6'b000010, 2'b00, 2'b01, 2'b10, 2'b00};
      12: return {6'b0, 2'b00, 2'b11, 2'b01, 2'b00};
      default: return 14'd0;
    endcase
  endfunction

  function automatic logic [13:0] obs();
    return {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite,
            ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, want);
    end
  endtask

  // Entered at a negedge; leaves at the negedge of the cycle after reset release.
  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b1; Zero = 1'b1;
    #1;
    check("rst_state", {28'd0, state_dbg}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_outs", {18'd0, obs()}, 32'd0);
      check("rst_instret", instret, 32'd0);
    end
    rst_n = 1'b1;
    #1 check("rel_state", {28'd0, state_dbg}, 32'd0);
    @(negedge clk);
    exp_cnt = 32'd0;
  endtask

  // Expands one instruction into its expected path and walks it cycle by cycle.
  // fw/mw are wait cycles at fetch and data access; zsel<0 randomizes Zero each cycle.
  task automatic run(input logic [31:0] ins, input int fw, input int mw, input int zsel);
    int   path[$];
    logic rdy[$];
    logic z;
    for (int i = 0; i <= fw; i++) begin path.push_back(1); rdy.push_back(i == fw); end
    path.push_back(2); rdy.push_back(1'($urandom));
    case (ins[6:0])
      7'b0110011: begin path.push_back(7); path.push_back(9); end
      7'b0010011: begin path.push_back(8); path.push_back(9); end
      7'b1101111: begin path.push_back(11); path.push_back(9); end
      7'b0110111: begin path.push_back(12); path.push_back(9); end
      7'b1100011: path.push_back(10);
      7'b0000011: path.push_back(3);
      7'b0100011: path.push_back(3);
      default:    path.push_back(13);
    endcase
    while (rdy.size() < path.size()) rdy.push_back(1'($urandom));
    if (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011) begin
      for (int i = 0; i <= mw; i++) begin
        path.push_back(ins[5] ? 6 : 4); rdy.push_back(i == mw);
      end
      if (!ins[5]) begin path.push_back(5); rdy.push_back(1'($urandom)); end
    end
    Instr = ins;
    for (int i = 0; i < path.size(); i++) begin
      z = (zsel < 0) ? 1'($urandom) : 1'(zsel);
      mem_ready = rdy[i]; Zero = z;
      #1;
      check("state", {28'd0, state_dbg}, path[i]);
      check("ctl", {18'd0, obs()}, {18'd0, ctl(path[i], rdy[i], z)});
      check("illegal", {31'd0, illegal}, 32'd0);
      @(negedge clk);
    end
    exp_cnt = exp_cnt + 32'd1;
    check("instret", instret, exp_cnt);
  endtask

  initial begin
    Instr = 32'd0;
    do_reset();

    run(32'h003100B3, 0, 0, -1);              // add
    run(32'h00012083, 0, 2, -1);              // lw with two memory wait cycles
    run(32'h00112023, 1, 1, -1);              // sw with fetch and store waits
    run(32'h00000063, 0, 0, 1);               // beq taken
    run(32'h00000063, 0, 0, 0);               // beq not taken
    run(32'h0040006F, 0, 0, -1);              // jal
    run(32'h123450B7, 0, 0, -1);              // lui
    run(32'h00508093, 0, 0, -1);              // addi

    // Counter wrap.
    force dut.instret = 32'hFFFFFFFF;
    #1 release dut.instret;
    exp_cnt = 32'hFFFFFFFF;
    check("preload", instret, 32'hFFFFFFFF);
    @(negedge clk);
    run(32'h003100B3, 0, 0, -1);

    // Random mix of all supported classes.
    for (int n = 0; n < 40; n++) begin
      logic [6:0]  ops [7];
      logic [31:0] ins;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
              7'b1100011, 7'b1101111, 7'b0110111};
      ins = {25'($urandom), ops[$urandom_range(0, 6)]};
      run(ins, $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

    // Reset in the middle of a load's memory wait aborts with no write-back.
    Instr = 32'h00012083;
    for (int i = 0; i < 3; i++) begin mem_ready = 1'b1; @(negedge clk); end
    mem_ready = 1'b0;
    #1 check("wait_state", {28'd0, state_dbg}, 32'd4);
    check("wait_req", {30'd0, mem_req, AdrSrc}, 32'd3);
    rst_n = 1'b0;
    #1 check("abort_state", {28'd0, state_dbg}, 32'd0);
    check("abort_outs", {18'd0, obs()}, 32'd0);
    check("abort_instret", instret, 32'd0);
    @(negedge clk);
    do_reset();
    run(32'h003100B3, 0, 0, -1);

    // Unknown opcode traps and stays trapped until reset.
    Instr = 32'h0000007F; mem_ready = 1'b1;
    #1 check("trap_fetch", {28'd0, state_dbg}, 32'd1);
    @(negedge clk);
    #1 check("trap_decode", {28'd0, state_dbg}, 32'd2);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'($urandom); Zero = 1'($urandom);
      #1;
      check("trap_state", {28'd0, state_dbg}, 32'd13);
      check("trap_illegal", {31'd0, illegal}, 32'd1);
      check("trap_outs", {18'd0, obs()}, 32'd0);
      check("trap_instret", instret, exp_cnt);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1 check("trap_clear", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    do_reset();
    run(32'h00000063, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
